// File: rtl/ultrasonic_pkg.sv
// Shared constants for the ultrasonic ranger: front-end timing at 50 MHz,
// distance conversion and the filter FSM state encoding.
package ultrasonic_pkg;

   localparam int CLK_HZ                = 50_000_000;
   localparam int TRIG_PULSE_CYCLES     = 500;        // 10 us trigger pulse
   localparam int ECHO_TIMEOUT_CYCLES   = 1_450_000;  // ~500 cm round trip
   localparam int MEASURE_PERIOD_CYCLES = 3_000_000;  // 60 ms between pings

   localparam int COUNTS_PER_CM = 2900;
   localparam int MAX_CM        = 400;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      DIV  = 2'd1,
      ACC  = 2'd2,
      OUT  = 2'd3
   } filt_state_e;

endpackage

// File: rtl/seq_divider.sv
// Restoring divider by a constant: one quotient bit per cycle, W cycles busy.
// done and quotient are presented combinationally in the final busy cycle.
module seq_divider #(
   parameter int W       = 21,
   parameter int DIVISOR = 2900
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         start,
   input  logic [W-1:0] dividend,
   output logic         busy,
   output logic         done,
   output logic [W-1:0] quotient
);

   localparam int         CNT_W       = (W > 1) ? $clog2(W) : 1;
   localparam logic [W:0] DIVISOR_EXT = (W+1)'(DIVISOR);

   logic [W-1:0]     rem_q, rem_d;
   logic [W-1:0]     quo_q, quo_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic             busy_q, busy_d;
   logic [W:0]       trial;

   always_comb begin
      rem_d  = rem_q;
      quo_d  = quo_q;
      cnt_d  = cnt_q;
      busy_d = busy_q;
      done   = 1'b0;
      // quo_q doubles as the dividend shift register while busy
      trial  = {rem_q, quo_q[W-1]};
      if (busy_q) begin
         if (trial >= DIVISOR_EXT) begin
            rem_d = W'(trial - DIVISOR_EXT);
            quo_d = {quo_q[W-2:0], 1'b1};
         end else begin
            rem_d = trial[W-1:0];
            quo_d = {quo_q[W-2:0], 1'b0};
         end
         cnt_d = cnt_q + CNT_W'(1);
         if (cnt_q == CNT_W'(W-1)) begin
            done   = 1'b1;
            busy_d = 1'b0;
         end
      end else if (start) begin
         rem_d  = '0;
         quo_d  = dividend;
         cnt_d  = '0;
         busy_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         rem_q  <= '0;
         quo_q  <= '0;
         cnt_q  <= '0;
         busy_q <= 1'b0;
      end else begin
         rem_q  <= rem_d;
         quo_q  <= quo_d;
         cnt_q  <= cnt_d;
         busy_q <= busy_d;
      end
   end

   assign busy     = busy_q;
   assign quotient = quo_d;

endmodule

// File: rtl/distance_cm_filter.sv
// Converts echo widths to centimetres, clamps to MAX_CM and reports a
// moving average over the last 2^AVG_LOG2 samples.
module distance_cm_filter #(
   parameter int RAW_W         = 21,
   parameter int CM_W          = 10,
   parameter int COUNTS_PER_CM = ultrasonic_pkg::COUNTS_PER_CM,
   parameter int MAX_CM        = ultrasonic_pkg::MAX_CM,
   parameter int AVG_LOG2      = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             new_measure,
   input  logic             timeout,
   input  logic [RAW_W-1:0] distance_raw,
   output logic [CM_W-1:0]  dist_cm,
   output logic             dist_valid,
   output logic             out_of_range,
   output logic             primed,
   output logic             overrun
);

   import ultrasonic_pkg::filt_state_e;
   import ultrasonic_pkg::IDLE;
   import ultrasonic_pkg::DIV;
   import ultrasonic_pkg::ACC;
   import ultrasonic_pkg::OUT;

   localparam int DEPTH = 1 << AVG_LOG2;
   localparam int SUM_W = CM_W + AVG_LOG2;

   filt_state_e         state_q, state_d;
   logic [CM_W-1:0]     sample_q, sample_d;
   logic                oor_q, oor_d;
   logic [CM_W-1:0]     buf_q [DEPTH];
   logic [CM_W-1:0]     buf_d [DEPTH];
   logic [AVG_LOG2-1:0] wptr_q, wptr_d;
   logic [AVG_LOG2:0]   cnt_q, cnt_d;
   logic [SUM_W-1:0]    sum_q, sum_d;
   logic [CM_W-1:0]     dist_cm_q, dist_cm_d;
   logic                dist_valid_q, dist_valid_d;
   logic                out_of_range_q, out_of_range_d;
   logic                primed_q, primed_d;
   logic                overrun_q, overrun_d;

   logic                div_start;
   logic                div_busy;
   logic                div_done;
   logic [RAW_W-1:0]    div_quot;

   seq_divider #(
      .W       (RAW_W),
      .DIVISOR (COUNTS_PER_CM)
   ) u_div (
      .clk      (clk),
      .rst      (rst),
      .start    (div_start),
      .dividend (distance_raw),
      .busy     (div_busy),
      .done     (div_done),
      .quotient (div_quot)
   );

   always_comb begin
      state_d        = state_q;
      sample_d       = sample_q;
      oor_d          = oor_q;
      buf_d          = buf_q;
      wptr_d         = wptr_q;
      cnt_d          = cnt_q;
      sum_d          = sum_q;
      dist_cm_d      = dist_cm_q;
      dist_valid_d   = 1'b0;
      out_of_range_d = out_of_range_q;
      primed_d       = primed_q;
      div_start      = 1'b0;
      // strobes are only accepted in IDLE; anything else is dropped and flagged
      overrun_d      = (state_q != IDLE) && (new_measure || timeout);

      case (state_q)
         IDLE: begin
            if (timeout) begin
               sample_d = CM_W'(MAX_CM);
               oor_d    = 1'b1;
               state_d  = ACC;
            end else if (new_measure && !div_busy) begin
               div_start = 1'b1;
               state_d   = DIV;
            end
         end
         DIV: begin
            if (div_done) begin
               if (div_quot > RAW_W'(MAX_CM)) begin
                  sample_d = CM_W'(MAX_CM);
                  oor_d    = 1'b1;
               end else begin
                  sample_d = div_quot[CM_W-1:0];
                  oor_d    = 1'b0;
               end
               state_d = ACC;
            end
         end
         ACC: begin
            buf_d[wptr_q]  = sample_q;
            sum_d          = sum_q + SUM_W'(sample_q) - SUM_W'(buf_q[wptr_q]);
            wptr_d         = wptr_q + AVG_LOG2'(1);
            if (cnt_q != (AVG_LOG2+1)'(DEPTH))
               cnt_d = cnt_q + (AVG_LOG2+1)'(1);
            if (cnt_q == (AVG_LOG2+1)'(DEPTH-1))
               primed_d = 1'b1;
            // outputs are registered here so they appear during OUT
            dist_cm_d      = sum_d[SUM_W-1:AVG_LOG2];
            out_of_range_d = oor_q;
            dist_valid_d   = 1'b1;
            state_d        = OUT;
         end
         OUT: begin
            state_d = IDLE;
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q        <= IDLE;
         sample_q       <= '0;
         oor_q          <= 1'b0;
         wptr_q         <= '0;
         cnt_q          <= '0;
         sum_q          <= '0;
         dist_cm_q      <= '0;
         dist_valid_q   <= 1'b0;
         out_of_range_q <= 1'b0;
         primed_q       <= 1'b0;
         overrun_q      <= 1'b0;
         for (int i = 0; i < DEPTH; i++)
            buf_q[i] <= '0;
      end else begin
         state_q        <= state_d;
         sample_q       <= sample_d;
         oor_q          <= oor_d;
         wptr_q         <= wptr_d;
         cnt_q          <= cnt_d;
         sum_q          <= sum_d;
         dist_cm_q      <= dist_cm_d;
         dist_valid_q   <= dist_valid_d;
         out_of_range_q <= out_of_range_d;
         primed_q       <= primed_d;
         overrun_q      <= overrun_d;
         for (int i = 0; i < DEPTH; i++)
            buf_q[i] <= buf_d[i];
      end
   end

   assign dist_cm      = dist_cm_q;
   assign dist_valid   = dist_valid_q;
   assign out_of_range = out_of_range_q;
   assign primed       = primed_q;
   assign overrun      = overrun_q;

endmodule

// File: tb/tb_distance_cm_filter.sv
// Directed bench for distance_cm_filter: latency, averaging, clamping,
// timeout priority, overrun and mid-operation reset.
module tb_distance_cm_filter;

   localparam int BUDGET = 60;

   logic        clk = 1'b0;
   logic        rst;
   logic        new_measure;
   logic        timeout;
   logic [20:0] distance_raw;
   logic [9:0]  dist_cm;
   logic        dist_valid;
   logic        out_of_range;
   logic        primed;
   logic        overrun;

   int total = 0;
   int bad   = 0;
   int lat;
   int ov_seen;
   int nv;

   distance_cm_filter #(
      .RAW_W         (21),
      .CM_W          (10),
      .COUNTS_PER_CM (2900),
      .MAX_CM        (400),
      .AVG_LOG2      (2)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .new_measure  (new_measure),
      .timeout      (timeout),
      .distance_raw (distance_raw),
      .dist_cm      (dist_cm),
      .dist_valid   (dist_valid),
      .out_of_range (out_of_range),
      .primed       (primed),
      .overrun      (overrun)
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
      end
   endtask

   // Drive one strobe and wait for dist_valid; lat counts cycles from the strobe.
   task automatic run(input logic nm, input logic to, input logic [20:0] raw);
      distance_raw = raw;
      new_measure  = nm;
      timeout      = to;
      ov_seen      = 0;
      tick();
      new_measure = 1'b0;
      timeout     = 1'b0;
      lat = 1;
      while (!dist_valid && lat < BUDGET) begin
         if (overrun) ov_seen = 1;
         tick();
         lat++;
      end
      if (overrun) ov_seen = 1;
   endtask

   task automatic expect_out(input string tag, input int exp_lat, input int exp_cm,
                             input logic exp_oor, input logic exp_primed);
      $display("txn %s lat=%0d cm=%0d oor=%0d primed=%0d", tag, lat, dist_cm, out_of_range, primed);
      chk({tag, "_lat"}, lat, exp_lat);
      chk({tag, "_cm"}, dist_cm, exp_cm);
      chk({tag, "_oor"}, out_of_range, exp_oor);
      chk({tag, "_primed"}, primed, exp_primed);
      tick();
      chk({tag, "_vpulse"}, dist_valid, 1'b0);
      chk({tag, "_hold"}, dist_cm, exp_cm);
   endtask

   task automatic count_valids(input int cycles);
      nv = 0;
      repeat (cycles) begin
         tick();
         if (dist_valid) nv++;
      end
   endtask

   initial begin
      rst          = 1'b1;
      new_measure  = 1'b0;
      timeout      = 1'b0;
      distance_raw = '0;
      repeat (3) tick();
      chk("rst_cm", dist_cm, 0);
      chk("rst_valid", dist_valid, 0);
      chk("rst_oor", out_of_range, 0);
      chk("rst_primed", primed, 0);
      chk("rst_overrun", overrun, 0);
      rst = 1'b0;
      tick();

      // 10, 20, 30, 40 cm; third one sits 1 count below 31 cm
      run(1'b1, 1'b0, 21'd29000);   expect_out("m10", 23, 2, 1'b0, 1'b0);
      run(1'b1, 1'b0, 21'd58000);   expect_out("m20", 23, 7, 1'b0, 1'b0);
      run(1'b1, 1'b0, 21'd89899);   expect_out("m30", 23, 15, 1'b0, 1'b0);
      run(1'b1, 1'b0, 21'd116000);  expect_out("m40", 23, 25, 1'b0, 1'b1);

      // window [0,20,30,40] -> 90/4
      run(1'b1, 1'b0, 21'd2899);    expect_out("m2899", 23, 22, 1'b0, 1'b1);
      // 500 cm clamps to 400: window [0,400,30,40] -> 470/4
      run(1'b1, 1'b0, 21'd1450000); expect_out("mclamp", 23, 117, 1'b1, 1'b1);

      // coincident strobes: timeout wins; window [0,400,400,40] -> 840/4
      run(1'b1, 1'b1, 21'd29000);
      chk("to_overrun", ov_seen, 0);
      expect_out("tmo", 2, 210, 1'b1, 1'b1);
      chk("to_overrun_after", overrun, 0);

      // window [0,400,400,0] -> 800/4
      run(1'b1, 1'b0, 21'd0);       expect_out("m0", 23, 200, 1'b0, 1'b1);

      // overrun: second strobe at cycle 5 of a 100 cm measurement
      distance_raw = 21'd290000;
      new_measure  = 1'b1;
      tick();
      new_measure = 1'b0;
      repeat (4) tick();
      distance_raw = 21'd1000000;
      new_measure  = 1'b1;
      chk("ovr_c5", overrun, 0);
      tick();
      new_measure = 1'b0;
      chk("ovr_c6", overrun, 1);
      tick();
      chk("ovr_c7", overrun, 0);
      lat = 7;
      while (!dist_valid && lat < BUDGET) begin
         tick();
         lat++;
      end
      // window [100,400,400,0] -> 900/4
      expect_out("movr", 23, 225, 1'b0, 1'b1);
      count_valids(40);
      chk("ovr_no_second", nv, 0);

      // reset at cycle 10 of DIV, with a strobe on the reset cycle
      distance_raw = 21'd29000;
      new_measure  = 1'b1;
      tick();
      new_measure = 1'b0;
      repeat (9) tick();
      rst          = 1'b1;
      new_measure  = 1'b1;
      tick();
      rst         = 1'b0;
      new_measure = 1'b0;
      chk("mrst_cm", dist_cm, 0);
      chk("mrst_valid", dist_valid, 0);
      chk("mrst_oor", out_of_range, 0);
      chk("mrst_primed", primed, 0);
      chk("mrst_overrun", overrun, 0);
      count_valids(30);
      chk("mrst_no_valid", nv, 0);

      // fresh start: only one sample in a zeroed window -> 40/4
      run(1'b1, 1'b0, 21'd116000);  expect_out("post", 23, 10, 1'b0, 1'b0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
